// File: rtl/pbus_bridge_gen2_pkg.sv
// Shared types and constants for the peripheral bus bridge.
package bridge_pkg;
    localparam int          MAX_SLOT     = 6;
    localparam logic [3:0]  CTRL_MASK    = 4'h0;
    localparam logic [3:0]  CTRL_PEND    = 4'h4;
    localparam logic [3:0]  CTRL_ERRADDR = 4'h8;
    localparam logic [3:0]  CTRL_ERRCNT  = 4'hC;
    localparam logic [31:0] ERR_DATA     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/pbus_bridge_gen2_if.sv
// CPU-side request/response and slave-side select/ack signals of the bridge.
interface pbus_bridge_gen2_if #(parameter int N_SLOT = 6);
    logic                  PrReq;
    logic                  PrWe;
    logic [31:0]           PrAddr;
    logic [31:0]           PrWD;
    logic [31:0]           PrRD;
    logic                  PrReady;
    logic                  PrErr;
    logic                  PrBusy;
    logic [N_SLOT-1:0]     dev_sel;
    logic                  dev_we;
    logic [7:0]            dev_addr;
    logic [31:0]           dev_wd;
    logic [N_SLOT*32-1:0]  dev_rd;
    logic [N_SLOT-1:0]     dev_ack;

    modport slave (
        input  PrReq, PrWe, PrAddr, PrWD, dev_rd, dev_ack,
        output PrRD, PrReady, PrErr, PrBusy, dev_sel, dev_we, dev_addr, dev_wd
    );
    modport master (
        output PrReq, PrWe, PrAddr, PrWD, dev_rd, dev_ack,
        input  PrRD, PrReady, PrErr, PrBusy, dev_sel, dev_we, dev_addr, dev_wd
    );
endinterface

// File: rtl/pbus_bridge_gen2_irq.sv
// Interrupt aggregation: input register, edge detect, pending/mask and HWInt register.
module bridge_irq_ctrl
    import bridge_pkg::*;
#(
    parameter int         N_SLOT     = 6,
    parameter logic [5:0] EDGE_MASK  = 6'b000011,
    parameter logic [5:0] MASK_RESET = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SLOT-1:0] irq,
    input  logic              mask_we,
    input  logic              pend_we,
    input  logic [5:0]        wdata,
    output logic [5:0]        mask,
    output logic [5:0]        pend,
    output logic [5:0]        hw_int
);
    localparam logic [5:0] SLOT_BITS = 6'((7'd1 << N_SLOT) - 7'd1);
    localparam logic [5:0] EDGE      = EDGE_MASK & SLOT_BITS;
    localparam logic [5:0] LEVEL     = ~EDGE_MASK & SLOT_BITS;

    logic [MAX_SLOT-1:0] irq_ext, irq_q, irq_prev, pend_edge, clr;

    always_comb begin
        irq_ext = '0;
        irq_ext[N_SLOT-1:0] = irq;
    end

    assign clr  = pend_we ? wdata : 6'd0;
    assign pend = (pend_edge & EDGE) | (irq_q & LEVEL);

    // A new rising edge is OR'd in after the clear, so set beats W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= '0;
            irq_prev  <= '0;
            pend_edge <= '0;
            mask      <= MASK_RESET;
            hw_int    <= '0;
        end else begin
            irq_q     <= irq_ext;
            irq_prev  <= irq_q;
            pend_edge <= ((pend_edge & ~clr) | (irq_q & ~irq_prev)) & EDGE;
            if (mask_we)
                mask <= wdata;
            hw_int    <= pend & mask & SLOT_BITS;
        end
    end
endmodule

// File: rtl/pbus_bridge_gen2.sv
// CPU-to-peripheral bridge: address decode, request/ack FSM with timeout, error log.
module pbus_bridge_gen2
    import bridge_pkg::*;
#(
    parameter int                   N_SLOT     = 6,
    parameter logic [N_SLOT*32-1:0] BASE_TABLE = {32'h7F40, 32'h7F38, 32'h7F34,
                                                  32'h7F2C, 32'h7F10, 32'h7F00},
    parameter logic [N_SLOT*32-1:0] SIZE_TABLE = {32'h4, 32'h8, 32'h4,
                                                  32'h8, 32'h1C, 32'hC},
    parameter logic [31:0]          CTRL_BASE  = 32'h0000_7F80,
    parameter int                   TIMEOUT    = 16,
    parameter logic [5:0]           EDGE_MASK  = 6'b000011,
    parameter logic [5:0]           MASK_RESET = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    pbus_bridge_gen2_if.slave bus,
    input  logic [N_SLOT-1:0] dev_irq,
    output logic [5:0]        HWInt
);
    localparam int IW = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam int TW = $clog2(TIMEOUT);

    state_t          state;
    logic [IW-1:0]   slot_idx, cur;
    logic [TW-1:0]   tcnt;
    logic [7:0]      slot_off;
    logic [31:0]     ctrl_rdata, req_addr, err_addr;
    logic [15:0]     err_cnt, err_cnt_nx;
    logic [5:0]      mask, pend;
    logic            ctrl_hit, slot_hit, req, mask_we, pend_we;

    function automatic logic in_slot(input int i, input logic [31:0] a);
        logic [32:0] lo, hi;
        lo = {1'b0, BASE_TABLE[i*32 +: 32]};
        hi = lo + {1'b0, SIZE_TABLE[i*32 +: 32]};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    // Walk slots from the top so the lowest matching index wins.
    always_comb begin
        ctrl_hit = (bus.PrAddr[31:4] == CTRL_BASE[31:4]);
        slot_hit = 1'b0;
        slot_idx = '0;
        slot_off = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (in_slot(i, bus.PrAddr)) begin
                slot_hit = 1'b1;
                slot_idx = IW'(i);
                slot_off = 8'(bus.PrAddr - BASE_TABLE[i*32 +: 32]);
            end
        end
    end

    always_comb begin
        case ({bus.PrAddr[3:2], 2'b00})
            CTRL_MASK:    ctrl_rdata = {26'd0, mask};
            CTRL_PEND:    ctrl_rdata = {26'd0, pend};
            CTRL_ERRADDR: ctrl_rdata = err_addr;
            default:      ctrl_rdata = {16'd0, err_cnt};
        endcase
    end

    assign req        = bus.PrReq && (state == S_IDLE);
    assign mask_we    = req && ctrl_hit && bus.PrWe && (bus.PrAddr[3:2] == CTRL_MASK[3:2]);
    assign pend_we    = req && ctrl_hit && bus.PrWe && (bus.PrAddr[3:2] == CTRL_PEND[3:2]);
    assign err_cnt_nx = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
    assign bus.PrBusy = (state != S_IDLE);

    bridge_irq_ctrl #(
        .N_SLOT(N_SLOT), .EDGE_MASK(EDGE_MASK), .MASK_RESET(MASK_RESET)
    ) u_irq (
        .clk(clk), .reset(reset), .irq(dev_irq), .mask_we(mask_we), .pend_we(pend_we),
        .wdata(bus.PrWD[5:0]), .mask(mask), .pend(pend), .hw_int(HWInt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cur          <= '0;
            tcnt         <= '0;
            req_addr     <= '0;
            err_addr     <= '0;
            err_cnt      <= '0;
            bus.PrRD     <= '0;
            bus.PrReady  <= 1'b0;
            bus.PrErr    <= 1'b0;
            bus.dev_sel  <= '0;
            bus.dev_we   <= 1'b0;
            bus.dev_addr <= '0;
            bus.dev_wd   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.PrReady <= 1'b0;
                    bus.PrErr   <= 1'b0;
                    if (bus.PrReq) begin
                        req_addr <= bus.PrAddr;
                        if (ctrl_hit) begin
                            bus.PrRD    <= ctrl_rdata;
                            bus.PrReady <= 1'b1;
                            state       <= S_DONE;
                        end else if (slot_hit) begin
                            cur          <= slot_idx;
                            tcnt         <= '0;
                            bus.dev_sel  <= N_SLOT'(1) << slot_idx;
                            bus.dev_we   <= bus.PrWe;
                            bus.dev_addr <= slot_off;
                            bus.dev_wd   <= bus.PrWD;
                            state        <= S_WAIT;
                        end else begin
                            bus.PrRD    <= ERR_DATA;
                            bus.PrReady <= 1'b1;
                            bus.PrErr   <= 1'b1;
                            err_addr    <= bus.PrAddr;
                            err_cnt     <= err_cnt_nx;
                            state       <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack is checked before the timeout so a last-cycle ack still completes.
                    if (bus.dev_ack[cur]) begin
                        bus.PrRD    <= bus.dev_rd[32*cur +: 32];
                        bus.PrReady <= 1'b1;
                        bus.dev_sel <= '0;
                        bus.dev_we  <= 1'b0;
                        state       <= S_DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.PrRD    <= ERR_DATA;
                        bus.PrReady <= 1'b1;
                        bus.PrErr   <= 1'b1;
                        bus.dev_sel <= '0;
                        bus.dev_we  <= 1'b0;
                        err_addr    <= req_addr;
                        err_cnt     <= err_cnt_nx;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    bus.PrReady <= 1'b0;
                    bus.PrErr   <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pbus_bridge_gen2.sv
// Bench for pbus_bridge_gen2: directed vector table, irq/reset/drop sequences, random traffic.
module tb_pbus_bridge_gen2;
    import bridge_pkg::*;

    localparam int NS = 6;
    localparam int TO = 16;
    localparam logic [31:0] CB = 32'h7F80;
    localparam logic [NS*32-1:0] BASES = {32'h7F40, 32'h7F38, 32'h7F34, 32'h7F2C, 32'h7F10, 32'h7F00};
    localparam logic [NS*32-1:0] SIZES = {32'h4, 32'h8, 32'h4, 32'h8, 32'h1C, 32'hC};
    localparam logic [5:0] EDGE = 6'b000011;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NS-1:0] dev_irq;
    logic [5:0] HWInt;
    always #5 clk = ~clk;

    pbus_bridge_gen2_if #(.N_SLOT(NS)) bus ();
    pbus_bridge_gen2 #(.N_SLOT(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dev_irq(dev_irq), .HWInt(HWInt));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: slot k acks in its (ack_lat[k]+1)-th select cycle; stray acks on idle slots.
    int ack_lat[NS];
    logic [31:0] rdata[NS];
    logic noise_en = 1'b0;
    int sel_cycles = 0;
    logic [NS-1:0] first_sel;
    logic [7:0] first_addr;
    logic first_we;
    logic [31:0] first_wd;

    always @(negedge clk) begin
        logic [NS-1:0] ack;
        ack = '0;
        if (bus.dev_sel != '0) begin
            if (sel_cycles == 0) begin
                first_sel = bus.dev_sel; first_addr = bus.dev_addr;
                first_we = bus.dev_we; first_wd = bus.dev_wd;
            end
            sel_cycles++;
            for (int k = 0; k < NS; k++)
                if (bus.dev_sel[k] && sel_cycles == ack_lat[k] + 1) ack[k] = 1'b1;
        end else sel_cycles = 0;
        if (noise_en) ack = ack | (NS'($urandom) & ~bus.dev_sel);
        bus.dev_ack = ack;
        for (int k = 0; k < NS; k++) bus.dev_rd[k*32 +: 32] = rdata[k];
    end

    task automatic req_pulse(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.PrReq = 1'b1; bus.PrWe = we; bus.PrAddr = a; bus.PrWD = d;
        @(posedge clk);
        #1 bus.PrReq = 1'b0;
    endtask

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int lat);
        first_sel = '0; first_addr = '0; first_we = 1'b0; first_wd = '0;
        req_pulse(we, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.PrReady && lat < 200);
        if (!bus.PrReady) begin
            checks++; errors++;
            $display("FAIL ready_wait: no PrReady for addr %h within 200 cycles", a);
        end
        rd = bus.PrRD; err = bus.PrErr;
    endtask

    // Reference model: register file state plus address map lookup.
    logic [5:0]  m_mask = 6'h3F;
    logic [5:0]  m_pend = 6'h00;
    logic [31:0] m_err_addr = '0;
    logic [15:0] m_err_cnt = '0;

    function automatic int m_slot(input logic [31:0] a);
        if (a >= CB && a < CB + 16) return -2;
        for (int k = 0; k < NS; k++)
            if (a >= BASES[k*32 +: 32] && (a - BASES[k*32 +: 32]) < SIZES[k*32 +: 32]) return k;
        return -1;
    endfunction

    task automatic m_update(input logic we, input logic [31:0] a, input logic [31:0] d, input int lat_cfg);
        int s;
        s = m_slot(a);
        if (s == -2 && we) begin
            if (((a - CB) >> 2) == 0) m_mask = d[5:0];
            if (((a - CB) >> 2) == 1) m_pend = m_pend & ~(d[5:0] & EDGE);
        end
        if (s == -1 || (s >= 0 && lat_cfg >= TO)) begin
            m_err_addr = a;
            if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 1;
        end
    endtask

    task automatic model_check(input string tag, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input int lat_cfg);
        logic [31:0] rd, erd;
        logic err, eerr;
        int lat, elat, s;
        for (int k = 0; k < NS; k++) ack_lat[k] = lat_cfg;
        access(we, a, d, rd, err, lat);
        s = m_slot(a);
        erd = ERR_DATA; eerr = 1'b1; elat = 1;
        if (s == -2) begin
            eerr = 1'b0;
            case ((a - CB) >> 2)
                0: erd = {26'd0, m_mask};
                1: erd = {26'd0, (m_pend & EDGE) | (dev_irq & ~EDGE)};
                2: erd = m_err_addr;
                default: erd = {16'd0, m_err_cnt};
            endcase
        end else if (s >= 0) begin
            chk({tag, "_sel"}, 32'(first_sel), 32'(1 << s));
            chk({tag, "_daddr"}, 32'(first_addr), 32'(8'(a - BASES[s*32 +: 32])));
            chk({tag, "_dwe"}, 32'(first_we), 32'(we));
            if (we) chk({tag, "_dwd"}, first_wd, d);
            if (lat_cfg < TO) begin eerr = 1'b0; elat = lat_cfg + 2; erd = rdata[s]; end
            else elat = TO + 1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        if (!we || eerr) chk({tag, "_rd"}, rd, erd);
        m_update(we, a, d, lat_cfg);
    endtask

    typedef struct {
        logic we; logic [31:0] addr; logic [31:0] wd; int lat;
        logic [31:0] rd; logic chk_rd; logic err; int rlat; logic [5:0] sel; logic [7:0] daddr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic [31:0] rd, input logic crd, input logic err, input int rlat,
                       input logic [5:0] sel, input logic [7:0] daddr);
        vec_t v;
        v.we = we; v.addr = a; v.wd = d; v.lat = lat; v.rd = rd; v.chk_rd = crd;
        v.err = err; v.rlat = rlat; v.sel = sel; v.daddr = daddr;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        int lat, rdy_cnt, rdy_cyc;
        logic rdy_err;

        bus.PrReq = 1'b0; bus.PrWe = 1'b0; bus.PrAddr = '0; bus.PrWD = '0;
        dev_irq = '0;
        for (int k = 0; k < NS; k++) begin ack_lat[k] = NEVER; rdata[k] = 32'hC0DE_0000 + k; end
        rdata[1] = 32'hA5A5_A5A5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd", bus.PrRD, 0);           chk("rst_ready", 32'(bus.PrReady), 0);
        chk("rst_err", 32'(bus.PrErr), 0);    chk("rst_busy", 32'(bus.PrBusy), 0);
        chk("rst_hwint", 32'(HWInt), 0);      chk("rst_sel", 32'(bus.dev_sel), 0);
        chk("rst_dwe", 32'(bus.dev_we), 0);   chk("rst_daddr", 32'(bus.dev_addr), 0);
        chk("rst_dwd", bus.dev_wd, 0);
        reset = 1'b0;
        noise_en = 1'b1;

        //  we  addr       wd            lat    rd            crd err rlat sel       daddr
        add(1, 32'h7F34, 32'h12345678, 0,     0,            0,  0,  2,  6'b001000, 8'h00);
        add(0, 32'h7F14, 0,            2,     32'hA5A5A5A5, 1,  0,  4,  6'b000010, 8'h04);
        add(0, 32'h7F50, 0,            0,     ERR_DATA,     1,  1,  1,  6'b000000, 8'h00);
        add(0, 32'h7F88, 0,            0,     32'h7F50,     1,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F8C, 0,            0,     32'h1,        1,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F00, 0,            NEVER, ERR_DATA,     1,  1,  17, 6'b000001, 8'h00);
        add(0, 32'h7F8C, 0,            0,     32'h2,        1,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F88, 0,            0,     32'h7F00,     1,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F0C, 0,            0,     ERR_DATA,     1,  1,  1,  6'b000000, 8'h00);
        add(0, 32'h7F0B, 0,            TO-1,  32'hC0DE0000, 1,  0,  17, 6'b000001, 8'h0B);
        add(0, 32'h7F2B, 0,            0,     32'hA5A5A5A5, 1,  0,  2,  6'b000010, 8'h1B);
        add(1, 32'h7F88, 0,            0,     0,            0,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F88, 0,            0,     32'h7F0C,     1,  0,  1,  6'b000000, 8'h00);
        add(1, 32'h7F8C, 0,            0,     0,            0,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F8C, 0,            0,     32'h3,        1,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F80, 0,            0,     32'h3F,       1,  0,  1,  6'b000000, 8'h00);
        add(1, 32'h7F80, 32'h15,       0,     0,            0,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F80, 0,            0,     32'h15,       1,  0,  1,  6'b000000, 8'h00);
        add(1, 32'h7F80, 32'h3F,       0,     0,            0,  0,  1,  6'b000000, 8'h00);
        add(0, 32'h7F43, 0,            1,     32'hC0DE0005, 1,  0,  3,  6'b100000, 8'h03);
        add(0, 32'h7F3F, 0,            0,     32'hC0DE0004, 1,  0,  2,  6'b010000, 8'h07);
        add(0, 32'h7F44, 0,            0,     ERR_DATA,     1,  1,  1,  6'b000000, 8'h00);

        foreach (tbl[i]) begin
            for (int k = 0; k < NS; k++) ack_lat[k] = tbl[i].lat;
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, rd, err, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].rlat));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
            if (tbl[i].chk_rd) chk($sformatf("v%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("v%0d_sel", i), 32'(first_sel), 32'(tbl[i].sel));
            if (tbl[i].sel != 0) begin
                chk($sformatf("v%0d_daddr", i), 32'(first_addr), 32'(tbl[i].daddr));
                chk($sformatf("v%0d_dwe", i), 32'(first_we), 32'(tbl[i].we));
                if (tbl[i].we) chk($sformatf("v%0d_dwd", i), first_wd, tbl[i].wd);
            end
            m_update(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].lat);
        end

        // A second request while the first is stalled must be dropped.
        for (int k = 0; k < NS; k++) ack_lat[k] = NEVER;
        req_pulse(0, 32'h7F00, 0);
        rdy_cnt = 0; rdy_cyc = 0; rdy_err = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.PrReady) begin rdy_cnt++; rdy_cyc = c; rdy_err = bus.PrErr; end
            bus.PrReq = (c == 5); bus.PrWe = 1'b1; bus.PrAddr = CB; bus.PrWD = 32'h0;
        end
        bus.PrReq = 1'b0;
        chk("drop_ready_cnt", 32'(rdy_cnt), 1);
        chk("drop_ready_cyc", 32'(rdy_cyc), TO + 1);
        chk("drop_err", 32'(rdy_err), 1);
        m_update(0, 32'h7F00, 0, NEVER);
        model_check("drop_mask", 0, CB, 0, 0);
        model_check("drop_cnt", 0, CB + 12, 0, 0);

        // Interrupts: edge pulse, W1C, masked pending, level follow.
        @(negedge clk) dev_irq[0] = 1'b1;
        @(negedge clk) dev_irq[0] = 1'b0;
        m_pend[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq0_hwint", 32'(HWInt), 32'h01);
        model_check("irq0_pend", 0, CB + 4, 0, 0);
        model_check("irq0_w1c", 1, CB + 4, 32'h1, 0);
        repeat (3) @(negedge clk);
        chk("irq0_cleared", 32'(HWInt), 0);
        model_check("irq0_pend_clr", 0, CB + 4, 0, 0);
        model_check("mask0", 1, CB, 32'h0, 0);
        @(negedge clk) dev_irq[1] = 1'b1;
        @(negedge clk) dev_irq[1] = 1'b0;
        m_pend[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq1_masked", 32'(HWInt), 0);
        model_check("mask3f", 1, CB, 32'h3F, 0);
        repeat (3) @(negedge clk);
        chk("irq1_unmasked", 32'(HWInt), 32'h02);
        model_check("irq1_w1c", 1, CB + 4, 32'h2, 0);
        dev_irq[3] = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq3_level", 32'(HWInt), 32'h08);
        model_check("irq3_w1c_ign", 1, CB + 4, 32'h8, 0);
        model_check("irq3_pend", 0, CB + 4, 0, 0);
        model_check("irq3_mask0", 1, CB, 32'h0, 0);
        repeat (3) @(negedge clk);
        chk("irq3_masked", 32'(HWInt), 0);
        dev_irq[3] = 1'b0;
        model_check("irq3_mask3f", 1, CB, 32'h3F, 0);
        repeat (3) @(negedge clk);
        chk("irq_idle", 32'(HWInt), 0);

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] a;
            int k;
            for (int j = 0; j < NS; j++) rdata[j] = $urandom;
            case ($urandom_range(0, 3))
                0: a = CB + 4 * $urandom_range(0, 3);
                1: begin
                    k = $urandom_range(0, NS - 1);
                    a = BASES[k*32 +: 32] + $urandom_range(0, SIZES[k*32 +: 32] - 1);
                end
                2: a = 32'h7F00 + $urandom_range(0, 255);
                default: a = $urandom;
            endcase
            model_check($sformatf("r%0d", it), 1'($urandom), a, $urandom, $urandom_range(0, 20));
        end

        // Reset in the middle of a stalled access.
        for (int k = 0; k < NS; k++) ack_lat[k] = NEVER;
        req_pulse(0, 32'h7F10, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.PrBusy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.PrReady), 0); chk("mid_rst_busy", 32'(bus.PrBusy), 0);
        chk("mid_rst_sel", 32'(bus.dev_sel), 0);   chk("mid_rst_rd", bus.PrRD, 0);
        chk("mid_rst_err", 32'(bus.PrErr), 0);     chk("mid_rst_daddr", 32'(bus.dev_addr), 0);
        reset = 1'b0;
        m_mask = 6'h3F; m_pend = '0; m_err_addr = '0; m_err_cnt = '0;
        rdy_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.PrReady) rdy_cnt++;
        end
        chk("mid_rst_no_ready", 32'(rdy_cnt), 0);
        model_check("post_rst_mask", 0, CB, 0, 0);
        model_check("post_rst_eaddr", 0, CB + 8, 0, 0);
        model_check("post_rst_ecnt", 0, CB + 12, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
